// File: rtl/fpc_pkg.sv
// fpc_pkg: definitions shared by the custom-float consumers (fpc_to_int) and
// the FPU. Custom float format: sign[31], exponent[30:25], mantissa[24:0],
// bias 31, hidden leading 1.
// Contents: format widths and field slices, the one-hot status encoding.
package fpc_pkg;

  localparam int WORD_W  = 32;
  localparam int EXP_W   = 6;
  localparam int MANT_W  = 25;
  localparam int BIAS    = 31;
  localparam int MAX_RSH = MANT_W + 2;   // flushes the whole 26-bit significand

  // Field slices inside a WORD_W operand.
  localparam int SIGN_BIT = WORD_W - 1;
  localparam int EXP_MSB  = WORD_W - 2;
  localparam int EXP_LSB  = MANT_W;
  localparam int MANT_MSB = MANT_W - 1;

  // Significand including the hidden bit.
  localparam int SIG_W = MANT_W + 1;

  // Exponent at which the significand is already an integer (no shift).
  localparam int UNIT_EXP = BIAS + MANT_W;

  // Largest left shift that still fits a positive WORD_W result.
  localparam int LSH_LIMIT = WORD_W - SIG_W;

  // Shift counter width; must hold MAX_RSH.
  localparam int CNT_W = 5;

  typedef enum logic [3:0] {
    EXACT     = 4'b0001,
    INEXACT   = 4'b0010,
    OVERFLOW  = 4'b0100,
    UNDERFLOW = 4'b1000
  } status_out_t;

endpackage

// File: rtl/fpc_to_int_if.sv
// fpc_to_int_if: request/result bus of the float-to-integer converter.
//   start      request, sampled only while busy is low
//   op_in      custom float operand, latched on accept
//   busy       conversion in progress
//   done       one-cycle pulse, int_out/status_out valid
//   int_out    signed two's-complement result, held until next done
//   status_out one-hot status, held until next done
// master: the requester; slave: the converter.
interface fpc_to_int_if;
  import fpc_pkg::*;

  logic                start;
  logic [WORD_W-1:0]   op_in;
  logic                busy;
  logic                done;
  logic [WORD_W-1:0]   int_out;
  status_out_t         status_out;

  modport master (
    output start, op_in,
    input  busy, done, int_out, status_out
  );

  modport slave (
    input  start, op_in,
    output busy, done, int_out, status_out
  );

endinterface

// File: rtl/fpc_unpack.sv
// fpc_unpack: combinational field splitter for the custom float format.
//   op        in   WORD_W  operand
//   sign      out  1       sign bit
//   exponent  out  EXP_W   biased exponent
//   sig       out  SIG_W   significand with the hidden 1 prepended
//   mant_zero out  1       stored mantissa is all zeros
//   zero      out  1       operand encodes zero (exponent and mantissa zero)
module fpc_unpack
  import fpc_pkg::*;
(
  input  logic [WORD_W-1:0] op,
  output logic              sign,
  output logic [EXP_W-1:0]  exponent,
  output logic [SIG_W-1:0]  sig,
  output logic              mant_zero,
  output logic              zero
);

  assign sign      = op[SIGN_BIT];
  assign exponent  = op[EXP_MSB:EXP_LSB];
  assign sig       = {1'b1, op[MANT_MSB:0]};
  assign mant_zero = (op[MANT_MSB:0] == '0);
  assign zero      = (exponent == '0) && mant_zero;

endmodule

// File: rtl/fpc_to_int.sv
// fpc_to_int: iterative custom-float to signed 32-bit integer converter.
// Shifts the significand one bit per clock, truncates toward zero and
// saturates on overflow.
//   clock100KHz  in  single clock, rising edge
//   reset        in  synchronous, active-high
//   bus          fpc_to_int_if.slave (start/op_in in; busy/done/int_out/status_out out)
// Flow: IDLE -> UNPACK -> SHIFT (k cycles, skipped when k=0) -> PACK -> IDLE.
module fpc_to_int
  import fpc_pkg::*;
(
  input  logic       clock100KHz,
  input  logic       reset,
  fpc_to_int_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_UNPACK, S_SHIFT, S_PACK} state_t;

  state_t             state_q, state_d;
  logic [WORD_W-1:0]  op_q, op_d;
  logic [WORD_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               left_q, left_d;
  logic               sticky_q, sticky_d;
  logic               ovf_q, ovf_d;
  logic [WORD_W-1:0]  int_q, int_d;
  status_out_t        status_q, status_d;
  logic               done_q, done_d;

  // Fields of the latched operand; op_q only changes on accept, so these
  // stay valid through PACK.
  logic              u_sign;
  logic [EXP_W-1:0]  u_exp;
  logic [SIG_W-1:0]  u_sig;
  logic              u_mant_zero;
  logic              u_zero;

  fpc_unpack u_unpack (
    .op        (op_q),
    .sign      (u_sign),
    .exponent  (u_exp),
    .sig       (u_sig),
    .mant_zero (u_mant_zero),
    .zero      (u_zero)
  );

  // Operand classification, consumed in UNPACK.
  logic              cls_left;
  logic              cls_ovf;
  logic [CNT_W-1:0]  cls_cnt;
  logic [EXP_W-1:0]  lsh;
  logic [EXP_W-1:0]  rsh;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    cls_left = 1'b0;
    cls_ovf  = 1'b0;
    cls_cnt  = '0;
    lsh      = '0;
    rsh      = '0;
    if (u_zero) begin
      cls_cnt = '0;
    end else if (u_exp >= EXP_W'(UNIT_EXP)) begin
      cls_left = 1'b1;
      lsh      = u_exp - EXP_W'(UNIT_EXP);
      // A shift of LSH_LIMIT reaches bit 31; only -2^31 is representable.
      cls_ovf  = (lsh > EXP_W'(LSH_LIMIT)) ||
                 ((lsh == EXP_W'(LSH_LIMIT)) && !(u_sign && u_mant_zero));
      cls_cnt  = cls_ovf ? '0 : CNT_W'(lsh);
    end else begin
      rsh     = EXP_W'(UNIT_EXP) - u_exp;
      cls_cnt = (rsh > EXP_W'(MAX_RSH)) ? CNT_W'(MAX_RSH) : CNT_W'(rsh);
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    int_d    = int_q;
    status_d = status_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // busy is low in IDLE, so any start here is accepted.
        if (bus.start) begin
          op_d    = bus.op_in;
          state_d = S_UNPACK;
        end
      end

      S_UNPACK: begin
        acc_d    = u_zero ? '0 : WORD_W'(u_sig);
        cnt_d    = cls_cnt;
        left_d   = cls_left;
        ovf_d    = cls_ovf;
        sticky_d = 1'b0;
        state_d  = (cls_cnt == '0) ? S_PACK : S_SHIFT;
      end

      S_SHIFT: begin
        if (left_q) begin
          acc_d = acc_q << 1;
        end else begin
          acc_d    = acc_q >> 1;
          sticky_d = sticky_q | acc_q[0];
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_PACK;
      end

      S_PACK: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (ovf_q) begin
          int_d    = u_sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
          status_d = OVERFLOW;
        end else begin
          int_d = u_sign ? -acc_q : acc_q;
          if (!u_zero && (acc_q == '0))
            status_d = UNDERFLOW;
          else if (sticky_q)
            status_d = INEXACT;
          else
            status_d = EXACT;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock100KHz) begin
    if (reset) begin
      state_q  <= S_IDLE;
      int_q    <= '0;
      status_q <= EXACT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      int_q    <= int_d;
      status_q <= status_d;
      done_q   <= done_d;
    end
  end

  // NOTE: the datapath is left without reset; it is always reloaded on
  // accept/UNPACK before it is used, and the FSM reset drops any stale value.
  always_ff @(posedge clock100KHz) begin
    op_q     <= op_d;
    acc_q    <= acc_d;
    cnt_q    <= cnt_d;
    left_q   <= left_d;
    sticky_q <= sticky_d;
    ovf_q    <= ovf_d;
  end

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done_q;
  assign bus.int_out    = int_q;
  assign bus.status_out = status_q;

endmodule

// File: tb/tb_fpc_to_int.sv
// tb_fpc_to_int: directed self-checking bench for fpc_to_int.
// Inputs change and outputs are sampled on the falling edge.
module tb_fpc_to_int;
  import fpc_pkg::*;

  logic clock100KHz = 1'b0;
  logic reset;

  fpc_to_int_if bus();

  fpc_to_int dut (
    .clock100KHz (clock100KHz),
    .reset       (reset),
    .bus         (bus)
  );

  always #5 clock100KHz = ~clock100KHz;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic [3:0]  st;
    int          edges;
  } vec_t;

  // Called at a falling edge with the DUT idle; returns at the falling edge
  // after the accepting edge E0.
  task automatic launch(input logic [31:0] op);
    bus.op_in = op;
    bus.start = 1'b1;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    bus.start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen, bounded.
  task automatic wait_done(output int edges, output logic got);
    edges = 0;
    got   = 1'b0;
    while (edges < 64) begin
      if (bus.done === 1'b1) begin
        got = 1'b1;
        break;
      end
      @(posedge clock100KHz);
      edges++;
      @(negedge clock100KHz);
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op_in = '0;
    repeat (2) @(posedge clock100KHz);
    @(negedge clock100KHz);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset busy: got %b expected 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_mis++; $display("FAIL reset done: got %b expected 0", bus.done); end
    n_cmp++;
    if (bus.int_out !== 32'h0) begin n_mis++; $display("FAIL reset int_out: got %h expected 00000000", bus.int_out); end
    n_cmp++;
    if (bus.status_out !== 4'b0001) begin n_mis++; $display("FAIL reset status: got %b expected 0001", bus.status_out); end
    reset = 1'b0;
    @(negedge clock100KHz);
  endtask

  task automatic test_conversions();
    vec_t vecs[16];
    int   edges;
    logic got;
    vecs[0]  = '{32'h3E00_0000, 32'h0000_0001, 4'b0001, 27};
    vecs[1]  = '{32'hC080_0000, 32'hFFFF_FFFE, 4'b0010, 26};
    vecs[2]  = '{32'h4080_0000, 32'h0000_0002, 4'b0010, 26};
    vecs[3]  = '{32'h3C00_0000, 32'h0000_0000, 4'b1000, 28};
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 4'b0001, 2};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0000, 4'b0001, 2};
    vecs[6]  = '{32'h7A00_0000, 32'h4000_0000, 4'b0001, 7};
    vecs[7]  = '{32'hFC00_0000, 32'h8000_0000, 4'b0001, 8};
    vecs[8]  = '{32'h7C00_0000, 32'h7FFF_FFFF, 4'b0100, 2};
    vecs[9]  = '{32'hFE00_0000, 32'h8000_0000, 4'b0100, 2};
    vecs[10] = '{32'hFC00_0001, 32'h8000_0000, 4'b0100, 2};
    vecs[11] = '{32'h0000_0001, 32'h0000_0000, 4'b1000, 29};
    vecs[12] = '{32'h7000_0001, 32'h0200_0001, 4'b0001, 2};
    vecs[13] = '{32'hF000_0001, 32'hFDFF_FFFF, 4'b0001, 2};
    vecs[14] = '{32'h7A00_0001, 32'h4000_0020, 4'b0001, 7};
    vecs[15] = '{32'h6E00_0003, 32'h0100_0001, 4'b0010, 3};
    for (int i = 0; i < 16; i++) begin
      launch(vecs[i].op);
      wait_done(edges, got);
      n_cmp++;
      if (!got) begin
        n_mis++;
        $display("FAIL conv[%0d] timeout op=%h: no done within %0d edges", i, vecs[i].op, edges);
      end else begin
        n_cmp++;
        if (bus.int_out !== vecs[i].res) begin n_mis++;
          $display("FAIL conv[%0d] int_out op=%h: got %h expected %h", i, vecs[i].op, bus.int_out, vecs[i].res); end
        n_cmp++;
        if (bus.status_out !== vecs[i].st) begin n_mis++;
          $display("FAIL conv[%0d] status op=%h: got %b expected %b", i, vecs[i].op, bus.status_out, vecs[i].st); end
        n_cmp++;
        if (edges !== vecs[i].edges) begin n_mis++;
          $display("FAIL conv[%0d] latency op=%h: got %0d edges expected %0d", i, vecs[i].op, edges, vecs[i].edges); end
        n_cmp++;
        if (bus.busy !== 1'b0) begin n_mis++;
          $display("FAIL conv[%0d] busy_in_done: got %b expected 0", i, bus.busy); end
        @(negedge clock100KHz);
        n_cmp++;
        if (bus.done !== 1'b0) begin n_mis++;
          $display("FAIL conv[%0d] done_pulse_width: got %b expected 0", i, bus.done); end
      end
    end
  endtask

  task automatic test_ignore_start();
    int   edges;
    int   pulses;
    logic got;
    launch(32'h3E00_0000);
    repeat (5) begin @(posedge clock100KHz); @(negedge clock100KHz); end
    bus.op_in = 32'h7C00_0000;
    bus.start = 1'b1;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    bus.start = 1'b0;
    wait_done(edges, got);
    edges += 6;
    n_cmp++;
    if (!got) begin
      n_mis++;
      $display("FAIL ignore_start timeout: no done");
    end else begin
      n_cmp++;
      if (bus.int_out !== 32'h1) begin n_mis++; $display("FAIL ignore_start int_out: got %h expected 00000001", bus.int_out); end
      n_cmp++;
      if (bus.status_out !== 4'b0001) begin n_mis++; $display("FAIL ignore_start status: got %b expected 0001", bus.status_out); end
      n_cmp++;
      if (edges !== 27) begin n_mis++; $display("FAIL ignore_start latency: got %0d expected 27", edges); end
    end
    pulses = 0;
    repeat (40) begin
      @(posedge clock100KHz);
      @(negedge clock100KHz);
      if (bus.done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_mis++; $display("FAIL ignore_start extra_done: got %0d expected 0", pulses); end
  endtask

  task automatic test_back_to_back();
    int   edges;
    logic got;
    bus.op_in = 32'h7A00_0000;
    bus.start = 1'b1;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    wait_done(edges, got);
    n_cmp++;
    if (!got || bus.int_out !== 32'h4000_0000 || edges !== 7) begin n_mis++;
      $display("FAIL b2b first: got done=%b int_out=%h edges=%0d expected 1 40000000 7", got, bus.int_out, edges); end
    // Still in the done cycle with start held: the next edge accepts.
    bus.op_in = 32'h4080_0000;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_mis++; $display("FAIL b2b no_gap busy: got %b expected 1", bus.busy); end
    wait_done(edges, got);
    n_cmp++;
    if (!got) begin
      n_mis++;
      $display("FAIL b2b second timeout: no done");
    end else begin
      n_cmp++;
      if (bus.int_out !== 32'h2) begin n_mis++; $display("FAIL b2b second int_out: got %h expected 00000002", bus.int_out); end
      n_cmp++;
      if (bus.status_out !== 4'b0010) begin n_mis++; $display("FAIL b2b second status: got %b expected 0010", bus.status_out); end
      n_cmp++;
      if (edges !== 26) begin n_mis++; $display("FAIL b2b second latency: got %0d expected 26", edges); end
    end
    @(negedge clock100KHz);
  endtask

  task automatic test_reset_mid();
    int pulses;
    launch(32'h3E00_0000);
    repeat (10) begin @(posedge clock100KHz); @(negedge clock100KHz); end
    reset = 1'b1;
    @(posedge clock100KHz);
    @(negedge clock100KHz);
    n_cmp++;
    if (bus.busy !== 1'b0) begin n_mis++; $display("FAIL reset_mid busy: got %b expected 0", bus.busy); end
    n_cmp++;
    if (bus.done !== 1'b0) begin n_mis++; $display("FAIL reset_mid done: got %b expected 0", bus.done); end
    n_cmp++;
    if (bus.int_out !== 32'h0) begin n_mis++; $display("FAIL reset_mid int_out: got %h expected 00000000", bus.int_out); end
    n_cmp++;
    if (bus.status_out !== 4'b0001) begin n_mis++; $display("FAIL reset_mid status: got %b expected 0001", bus.status_out); end
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock100KHz);
      @(negedge clock100KHz);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin n_mis++; $display("FAIL reset_mid stale_activity: got %0d cycles expected 0", pulses); end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op_in = '0;
    test_reset();
    test_conversions();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
